// File: rtl/debug_dump_seq.sv
// Debug-dump sequencer: streams header, regs, latches, memory window and cycle count MSB-byte-first to a UART.
// Latency: first o_tx_start 2 cycles after i_start; one byte every >=4 cycles; memory words cost 2 extra cycles.
// Backpressure: waits for i_tx_done to fall then rise per byte. DEBUG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module debug_dump_seq #(
    parameter int UART_BITS  = 8,
    parameter int WORD_BITS  = 32,
    parameter int NUM_REGS   = 32,
    parameter int LATCH_BITS = 256,
    parameter int CNT_BITS   = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [3:0]                    i_mask,
    input  logic [ADDR_BITS-1:0]          i_mem_base,
    input  logic [ADDR_BITS:0]            i_mem_count,
    input  logic                          i_tx_done,
    input  logic [NUM_REGS*WORD_BITS-1:0] i_rf_regs,
    input  logic [LATCH_BITS-1:0]         i_latches,
    input  logic [WORD_BITS-1:0]          i_mem_data,
    input  logic [CNT_BITS-1:0]           i_clk_count,
    output logic                          o_debug_read_data,
    output logic [ADDR_BITS-1:0]          o_debug_read_address,
    output logic                          o_tx_start,
    output logic [UART_BITS-1:0]          o_tx_data,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int WORD_BYTES = WORD_BITS / UART_BITS;
    localparam int RF_BITS    = NUM_REGS * WORD_BITS;
    localparam int REG_BYTES  = NUM_REGS * WORD_BYTES;
    localparam int LAT_BYTES  = (LATCH_BITS + UART_BITS - 1) / UART_BITS;
    localparam int LAT_PAD    = LAT_BYTES * UART_BITS;
    localparam int CNT_BYTES  = CNT_BITS / UART_BITS;
    localparam int BL_W       = 16;

    localparam logic [2:0] SEC_HDR  = 3'd0;
    localparam logic [2:0] SEC_REGS = 3'd1;
    localparam logic [2:0] SEC_LAT  = 3'd2;
    localparam logic [2:0] SEC_MEM  = 3'd3;
    localparam logic [2:0] SEC_CNT  = 3'd4;
    localparam logic [2:0] SEC_CKS  = 3'd5;
    localparam logic [2:0] SEC_END  = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_MEM_REQ,
        S_MEM_WAIT,
`ifdef DEBUG_DUMP_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            sec_q, sec_d;
    logic [BL_W-1:0]       byte_left_q, byte_left_d;
    logic [ADDR_BITS:0]    words_left_q, words_left_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]            mask_q, mask_d;
    logic [RF_BITS-1:0]    regs_q, regs_d;
    logic [LAT_PAD-1:0]    lat_q, lat_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [WORD_BITS-1:0]  word_q, word_d;
    logic [UART_BITS-1:0]  cksum_q, cksum_d;
    logic                  tx_start_q, tx_start_d;
    logic [UART_BITS-1:0]  tx_data_q, tx_data_d;
    logic                  rd_q, rd_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [UART_BITS-1:0]  hdr_byte;
    logic [UART_BITS-1:0]  load_byte;
    logic [2:0]            nsec;

    // Later assignments win, so the earliest enabled section after cur is chosen.
    function automatic logic [2:0] next_sec(input logic [2:0] cur, input logic [3:0] m,
                                            input logic mem_nz);
        logic [2:0] n;
        n = SEC_END;
        if (cur < SEC_CNT && m[0])           n = SEC_CNT;
        if (cur < SEC_MEM && m[1] && mem_nz) n = SEC_MEM;
        if (cur < SEC_LAT && m[2])           n = SEC_LAT;
        if (cur < SEC_REGS && m[3])          n = SEC_REGS;
        return n;
    endfunction

    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        byte_left_d  = byte_left_q;
        words_left_d = words_left_q;
        mem_addr_d   = mem_addr_q;
        mask_d       = mask_q;
        regs_d       = regs_q;
        lat_d        = lat_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        cksum_d      = cksum_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        rd_d         = 1'b0;
        rd_addr_d    = rd_addr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        nsec         = SEC_END;

        hdr_byte = UART_BITS'({4'hA, mask_q});
        case (sec_q)
            SEC_REGS: load_byte = regs_q[RF_BITS-1 -: UART_BITS];
            SEC_LAT:  load_byte = lat_q[LAT_PAD-1 -: UART_BITS];
            SEC_MEM:  load_byte = word_q[WORD_BITS-1 -: UART_BITS];
            default:  load_byte = cnt_q[CNT_BITS-1 -: UART_BITS];
        endcase

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mask_d       = i_mask;
                    mem_addr_d   = i_mem_base;
                    words_left_d = i_mem_count;
                    regs_d       = i_rf_regs;
                    lat_d        = LAT_PAD'(i_latches);
                    cnt_d        = i_clk_count;
                    busy_d       = 1'b1;
                    state_d      = S_HDR;
                end
            end
            S_HDR: begin
                tx_data_d   = hdr_byte;
                cksum_d     = hdr_byte;
                tx_start_d  = 1'b1;
                sec_d       = SEC_HDR;
                byte_left_d = '0;
                state_d     = S_SEND;
            end
            S_LOAD: begin
                tx_data_d   = load_byte;
                cksum_d     = cksum_q ^ load_byte;
                tx_start_d  = 1'b1;
                byte_left_d = byte_left_q - BL_W'(1);
                case (sec_q)
                    SEC_REGS: regs_d = regs_q << UART_BITS;
                    SEC_LAT:  lat_d  = lat_q << UART_BITS;
                    SEC_MEM:  word_d = word_q << UART_BITS;
                    default:  cnt_d  = cnt_q << UART_BITS;
                endcase
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!i_tx_done) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_tx_done) begin
                    if (byte_left_q != '0) begin
                        state_d = S_LOAD;
                    end else if (sec_q == SEC_MEM && words_left_q != '0) begin
                        rd_d      = 1'b1;
                        rd_addr_d = mem_addr_q;
                        state_d   = S_MEM_REQ;
                    end else begin
                        nsec  = (sec_q == SEC_CKS) ? SEC_END
                                                   : next_sec(sec_q, mask_q, words_left_q != '0);
                        sec_d = nsec;
                        case (nsec)
                            SEC_REGS: begin
                                byte_left_d = BL_W'(REG_BYTES);
                                state_d     = S_LOAD;
                            end
                            SEC_LAT: begin
                                byte_left_d = BL_W'(LAT_BYTES);
                                state_d     = S_LOAD;
                            end
                            SEC_MEM: begin
                                rd_d      = 1'b1;
                                rd_addr_d = mem_addr_q;
                                state_d   = S_MEM_REQ;
                            end
                            SEC_CNT: begin
                                byte_left_d = BL_W'(CNT_BYTES);
                                state_d     = S_LOAD;
                            end
                            default: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                                if (sec_q != SEC_CKS) begin
                                    state_d = S_CKSUM;
                                end else begin
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                    state_d = S_DONE;
                                end
`else
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = S_DONE;
`endif
                            end
                        endcase
                    end
                end
            end
            S_MEM_REQ: state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                // Read data is valid the cycle after the strobe.
                word_d       = i_mem_data;
                byte_left_d  = BL_W'(WORD_BYTES);
                mem_addr_d   = mem_addr_q + ADDR_BITS'(1);
                words_left_d = words_left_q - (ADDR_BITS+1)'(1);
                state_d      = S_LOAD;
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            S_CKSUM: begin
                tx_data_d   = cksum_q;
                tx_start_d  = 1'b1;
                sec_d       = SEC_CKS;
                byte_left_d = '0;
                state_d     = S_SEND;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sec_q        <= SEC_HDR;
            byte_left_q  <= '0;
            words_left_q <= '0;
            mem_addr_q   <= '0;
            mask_q       <= '0;
            regs_q       <= '0;
            lat_q        <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            cksum_q      <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            rd_q         <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            byte_left_q  <= byte_left_d;
            words_left_q <= words_left_d;
            mem_addr_q   <= mem_addr_d;
            mask_q       <= mask_d;
            regs_q       <= regs_d;
            lat_q        <= lat_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            cksum_q      <= cksum_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            rd_q         <= rd_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_tx_start           = tx_start_q;
    assign o_tx_data            = tx_data_q;
    assign o_debug_read_data    = rd_q;
    assign o_debug_read_address = rd_addr_q;
    assign o_busy               = busy_q;
    assign o_done               = done_q;

endmodule

// File: tb/tb_debug_dump_seq.sv
// Scoreboard bench for debug_dump_seq with a UART busy model and a one-cycle-latency memory model.
module tb_debug_dump_seq;

    localparam int NR = 32;
    localparam int LB = 256;
    localparam int AB = 10;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [3:0]    i_mask = '0;
    logic [AB-1:0] i_mem_base = '0;
    logic [AB:0]   i_mem_count = '0;
    logic          i_tx_done;
    logic [NR*32-1:0] rf = '0;
    logic [LB-1:0] lat = '0;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   clk_count = '0;
    logic          o_debug_read_data;
    logic [AB-1:0] o_debug_read_address;
    logic          o_tx_start;
    logic [7:0]    o_tx_data;
    logic          o_busy;
    logic          o_done;

    logic [31:0]   rf_w[NR];
    logic [7:0]    exp_q[$];
    logic [AB-1:0] addr_q[$];
    logic [7:0]    ck;
    int            n_err = 0;
    int            n_chk = 0;
    int            tx_cnt = 0;
    int            done_cnt = 0;
    int            busy_len = 3;
    int            busy_cnt = 0;
    logic          hold_low = 1'b0;

    always #5 clk = ~clk;

    debug_dump_seq dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (i_start),
        .i_mask               (i_mask),
        .i_mem_base           (i_mem_base),
        .i_mem_count          (i_mem_count),
        .i_tx_done            (i_tx_done),
        .i_rf_regs            (rf),
        .i_latches            (lat),
        .i_mem_data           (mem_rdata),
        .i_clk_count          (clk_count),
        .o_debug_read_data    (o_debug_read_data),
        .o_debug_read_address (o_debug_read_address),
        .o_tx_start           (o_tx_start),
        .o_tx_data            (o_tx_data),
        .o_busy               (o_busy),
        .o_done               (o_done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // UART: idle level drops the cycle after a start pulse and stays low busy_len cycles.
    always @(posedge clk) begin
        if (o_tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign i_tx_done = (busy_cnt == 0) && !hold_low;

    always @(posedge clk) begin
        if (o_debug_read_data) mem_rdata <= 32'(o_debug_read_address) + 32'd1;
    end

    always @(negedge clk) begin
        if (o_tx_start) begin
            tx_cnt++;
            if (exp_q.size() == 0) check("extra_byte", 64'(exp_q.size()), 64'd1);
            else check($sformatf("byte%0d", tx_cnt), 64'(o_tx_data), 64'(exp_q.pop_front()));
        end
        if (o_debug_read_data) begin
            if (addr_q.size() == 0) check("extra_read", 64'(addr_q.size()), 64'd1);
            else check("rd_addr", 64'(o_debug_read_address), 64'(addr_q.pop_front()));
        end
        if (o_done) done_cnt++;
    end

    task automatic push_b(input logic [7:0] b);
        exp_q.push_back(b);
        ck = ck ^ b;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) push_b(w[31-8*b -: 8]);
    endtask

    task automatic build_expect(input logic [3:0] m, input logic [AB-1:0] base, input logic [AB:0] cnt);
        logic [AB-1:0] a;
        logic [7:0]    fin;
        ck = 8'h00;
        push_b({4'hA, m});
        if (m[3]) for (int r = 0; r < NR; r++) push_word(rf_w[r]);
        if (m[2]) for (int i = 0; i < LB/8; i++) push_b(lat[LB-1-8*i -: 8]);
        if (m[1]) begin
            for (int k = 0; k < int'(cnt); k++) begin
                a = base + AB'(k);
                addr_q.push_back(a);
                push_word(32'(a) + 32'd1);
            end
        end
        if (m[0]) push_word(clk_count);
        fin = ck;
        if (CK == 1) exp_q.push_back(fin);
    endtask

    task automatic start_dump(input logic [3:0] m, input logic [AB-1:0] base, input logic [AB:0] cnt);
        for (int r = 0; r < NR; r++) rf[(NR-1-r)*32 +: 32] = rf_w[r];
        build_expect(m, base, cnt);
        @(negedge clk);
        i_mask = m; i_mem_base = base; i_mem_count = cnt; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_set", 64'(o_busy), 64'd1);
        check("start_lat1", 64'(o_tx_start), 64'd0);
        @(negedge clk);
        check("start_lat2", 64'(o_tx_start), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_left"}, 64'(exp_q.size() + addr_q.size()), 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_start"}, 64'(o_tx_start), 64'd0);
        check({tag, "_data"}, 64'(o_tx_data), 64'd0);
        check({tag, "_rd"}, 64'(o_debug_read_data), 64'd0);
        check({tag, "_addr"}, 64'(o_debug_read_address), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int d0;
        for (int r = 0; r < NR; r++) rf_w[r] = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clock count only, 3-cycle UART busy.
        clk_count = 32'h0000009C;
        t0 = tx_cnt;
        start_dump(4'h1, '0, '0);
        wait_done("cnt");
        check("cnt_nbytes", 64'(tx_cnt - t0), 64'(5 + CK));

        // Register file only.
        rf_w[0] = 32'd5;
        rf_w[1] = 32'd8;
        t0 = tx_cnt;
        start_dump(4'h8, '0, '0);
        wait_done("regs");
        check("regs_nbytes", 64'(tx_cnt - t0), 64'(129 + CK));

        // Memory window wrapping past the top address.
        start_dump(4'h2, 10'h3FE, 11'd3);
        wait_done("mem");

        // Everything enabled, random contents, near-ideal UART.
        busy_len = 1;
        for (int r = 0; r < NR; r++) rf_w[r] = $urandom;
        for (int i = 0; i < LB/32; i++) lat[i*32 +: 32] = $urandom;
        clk_count = $urandom;
        start_dump(4'hF, AB'($urandom), 11'd2);
        wait_done("all");

        // Memory enabled but empty window.
        start_dump(4'h3, 10'h011, 11'd0);
        wait_done("mem0");

        // Header only.
        t0 = tx_cnt;
        start_dump(4'h0, '0, '0);
        wait_done("hdr");
        check("hdr_nbytes", 64'(tx_cnt - t0), 64'(1 + CK));

        // UART stuck busy for 50 cycles after a send.
        busy_len = 2;
        t0 = tx_cnt;
        start_dump(4'h1, '0, '0);
        hold_low = 1'b1;
        repeat (50) @(negedge clk);
        check("hold_nostart", 64'(tx_cnt - t0), 64'd1);
        hold_low = 1'b0;
        wait_done("hold");

        // Second start mid-dump ignored, then reset during WAIT_DONE aborts.
        busy_len = 3;
        start_dump(4'h8, '0, '0);
        repeat (20) @(negedge clk);
        i_mask = 4'h1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("restart_ignored", 64'(o_busy), 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_tx_start) break;
        end
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0 = tx_cnt;
        repeat (30) @(negedge clk);
        check("abort_nostart", 64'(tx_cnt - t0), 64'd0);
        check("abort_nodone", 64'(done_cnt - d0), 64'd0);
        clk_count = 32'h12345678;
        start_dump(4'h1, '0, '0);
        wait_done("fresh");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/debug_dump_seq.md
# debug_dump_seq

Parametrised debug-dump sequencer for the pipelined MIPS debug unit. On a start request it snapshots the processor's debug state and streams it, MSB byte first, to the UART transmitter over a start/done handshake. Data-memory words are read through the debug read port. Compared with the single fixed-layout dump, it adds configurable widths and depths, a runtime section-select mask and a programmable memory window.

## Interface
Parameters:
- UART_BITS, 8, UART byte width.
- WORD_BITS, 32, register/memory word width; must be a multiple of UART_BITS.
- NUM_REGS, 32, register-file words dumped.
- LATCH_BITS, 256, total concatenated pipeline-latch bits (IF/ID..MEM/WB).
- CNT_BITS, 32, clock-count width; must be a multiple of UART_BITS.
- ADDR_BITS, 10, data-memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  one-cycle dump request.
- i_mask  in  4  section enables: [3] regs, [2] latches, [1] memory, [0] clock count.
- i_mem_base  in  ADDR_BITS  first memory word address.
- i_mem_count  in  ADDR_BITS+1  number of memory words (0 = none).
- i_tx_done  in  1  UART idle level (1 = idle).
- i_rf_regs  in  NUM_REGS*WORD_BITS  register file, reg 0 in MSBs.
- i_latches  in  LATCH_BITS  pipeline latches, concatenated.
- i_mem_data  in  WORD_BITS  memory read data.
- i_clk_count  in  CNT_BITS  processor cycle count.
- o_debug_read_data  out  1  memory read strobe.
- o_debug_read_address  out  ADDR_BITS  memory read address.
- o_tx_start  out  1  one-cycle UART send pulse.
- o_tx_data  out  UART_BITS  byte to send.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse after the last byte completes.

## Operation
- States: IDLE, HDR, LOAD, SEND, WAIT_BUSY, WAIT_DONE, MEM_REQ, MEM_WAIT, CKSUM, DONE.
- IDLE: when i_start=1, snapshot i_mask, i_mem_base, i_mem_count, i_rf_regs, i_latches and i_clk_count; set o_busy; go to HDR. i_start is ignored while o_busy=1.
- Byte stream order:
  - header {4'hA, mask};
  - regs: NUM_REGS*WORD_BITS/UART_BITS bytes;
  - latches: ceil(LATCH_BITS/UART_BITS) bytes, zero-padded in the MSBs of the first byte;
  - memory: i_mem_count words, each MSB byte first;
  - clock count: CNT_BITS/UART_BITS bytes.
- Sections with a mask bit of 0 are skipped entirely. A memory section with count 0 emits nothing.
- Per byte: LOAD places the byte on o_tx_data → SEND pulses o_tx_start for 1 cycle → WAIT_BUSY waits for i_tx_done=0 → WAIT_DONE waits for i_tx_done=1 → next byte.
- Memory word: MEM_REQ drives o_debug_read_data=1 with the address for 1 cycle → MEM_WAIT latches i_mem_data on the following cycle → the word's bytes are sent.
- Memory addresses run i_mem_base + k (k = 0..count-1) and wrap modulo 2^ADDR_BITS.
- After the final byte (or after CKSUM, if configured): DONE pulses o_done for 1 cycle, clears o_busy, returns to IDLE.
- Mask 4'h0: the header byte only is sent, then done.
- o_tx_data stays stable from LOAD until WAIT_DONE exits.

## Timing
- Reset values: o_tx_start=0, o_tx_data=0, o_debug_read_data=0, o_debug_read_address=0, o_busy=0, o_done=0; state IDLE.
- Reset asserted mid-dump aborts immediately: no o_done, and no further o_tx_start.
- i_start → first o_tx_start: 2 cycles (HDR, then SEND).
- Byte-to-byte minimum with an ideal UART: 4 cycles.
- Memory read strobe → data sampled: 1 cycle.
- o_done is asserted the cycle after the final WAIT_DONE exit.
- i_tx_done already low at SEND: WAIT_BUSY exits immediately.

## Configuration
- DEBUG_DUMP_CHECKSUM_EN:
  - Defined: after the last section, CKSUM sends one extra byte equal to the XOR of every preceding byte, header included.
  - Undefined: no CKSUM state; the stream ends at the last section byte.

## Test plan
- Reset, mask=4'h1, i_clk_count=32'h0000009C, UART model with 3-cycle busy → bytes A1,00,00,00,9C; one o_done pulse; o_busy low afterwards.
- mask=4'h8, NUM_REGS=32, reg0=5, reg1=8, rest 0 → 129 bytes: A8, 00 00 00 05, 00 00 00 08, then 120 bytes of 00.
- mask=4'h2, base=10'h3FE, count=3, memory returns addr+1 → read addresses 3FE, 3FF, 000 (wrap); data words 3FF, 400, 001.
- i_start pulsed mid-dump, then rst asserted during WAIT_DONE → second start ignored; after rst all outputs 0, no o_done; a fresh dump then succeeds.
- mask=4'h0 → single byte A0 then o_done. With DEBUG_DUMP_CHECKSUM_EN defined → bytes A0, A0.
- i_tx_done held low for 50 cycles after a SEND → no new o_tx_start until i_tx_done returns to 1.
